// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: exception field widths and the per-fetch
// exception bundle passed from IF to ID, plus the fetch queue entry layout.
package cpu_pkg;

    localparam int ECODE_W    = 6;
    localparam int ESUBCODE_W = 9;

    // Exception information attached to a fetch; all-zero for a clean fetch
    typedef struct packed {
        logic                  has_exception;
        logic [ECODE_W-1:0]    ecode;
        logic [ESUBCODE_W-1:0] esubcode;
        logic [31:0]           maddr;
    } fetch_exc_t;

    // One fetch queue slot. "done" means the instruction word is final,
    // either because memory answered or because the fetch faulted in IF.
    typedef struct packed {
        logic       valid;
        logic       done;
        logic [31:0] pc;
        logic [31:0] inst;
        fetch_exc_t exc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_discard_ctr.sv
// Tracks live memory requests (inflight) and responses that belong to
// flushed fetches (discard). Decides for every data_ok beat whether it
// fills a queue entry or is silently swallowed.
module fetch_discard_ctr #(
    parameter int MAX_OUTSTANDING = 3,
    parameter int DIS_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_mem,
    input  logic             data_ok,
    input  logic             flush,
    output logic [DIS_W-1:0] inflight,
    output logic [DIS_W-1:0] discard,
    output logic             fill_en
);

    logic             drop;
    logic [DIS_W-1:0] inflight_next;
    logic [DIS_W-1:0] discard_next;

    // Classify the incoming beat: stale beats are eaten first, in order,
    // and a beat with nothing outstanding at all is ignored
    always_comb begin
        drop    = data_ok && (discard != '0);
        fill_en = data_ok && (discard == '0) && (inflight != '0);
    end

    // On flush every live request (including one accepted this very cycle)
    // turns into a pending discard, minus the beat that filled this cycle.
    // Intermediate wrap is harmless: the final value never exceeds
    // MAX_OUTSTANDING because allocation is throttled on inflight+discard.
    always_comb begin
        inflight_next = inflight;
        discard_next  = discard;
        if (flush) begin
            inflight_next = '0;
            discard_next  = discard + inflight + DIS_W'(alloc_mem)
                          - DIS_W'(fill_en) - DIS_W'(drop);
        end else begin
            inflight_next = inflight + DIS_W'(alloc_mem) - DIS_W'(fill_en);
            discard_next  = discard - DIS_W'(drop);
        end
    end

    // Counter registers; reset also clears discards since memory resets too
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            discard  <= discard_next;
        end
    end

    // A response with nothing outstanding means the memory side misbehaved
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(data_ok && (inflight == '0) && (discard == '0)));
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order instruction fetch queue between IF and ID. Entries are allocated
// when IF issues (or pre-faults) a fetch, filled in order by data_ok beats,
// and presented to ID from the head. Flushes drop every entry and leave the
// discard counter to swallow responses still on their way.
module inst_fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 3,
    parameter int CNT_W           = $clog2(DEPTH + 1),
    parameter int DIS_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [31:0]           alloc_pc,
    input  logic                  alloc_has_exception,
    input  logic [ECODE_W-1:0]    alloc_ecode,
    input  logic [ESUBCODE_W-1:0] alloc_esubcode,
    input  logic [31:0]           alloc_maddr,
    input  logic                  data_ok,
    input  logic [31:0]           rdata,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           inst_out,
    output logic [31:0]           pc_out,
    output logic                  has_exception_out,
    output logic [ECODE_W-1:0]    ecode_out,
    output logic [ESUBCODE_W-1:0] esubcode_out,
    output logic [31:0]           exception_maddr_out,
    output logic [DIS_W-1:0]      inflight,
    output logic [DIS_W-1:0]      discard
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fill;
    logic [CNT_W-1:0] count;

    logic             alloc_fire;
    logic             alloc_mem;
    logic             deq;
    logic             fill_en;
    logic             fill_found;
    logic [PTR_W-1:0] fill_hit;
    logic [PTR_W-1:0] probe;
    fq_entry_t        alloc_entry;
    fq_entry_t        head_entry;

    fetch_discard_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .DIS_W           (DIS_W)
    ) u_discard_ctr (
        .clk       (clk),
        .rst       (rst),
        .alloc_mem (alloc_mem),
        .data_ok   (data_ok),
        .flush     (flush),
        .inflight  (inflight),
        .discard   (discard),
        .fill_en   (fill_en)
    );

    // Admission: room in the queue and in the memory request budget. The
    // budget counts discards too, so stale beats can never overrun it.
    always_comb begin
        alloc_ready = !rst
                   && (count < CNT_W'(DEPTH))
                   && (((DIS_W+1)'(inflight) + (DIS_W+1)'(discard))
                       < (DIS_W+1)'(MAX_OUTSTANDING));
        alloc_fire  = alloc_valid && alloc_ready;
        alloc_mem   = alloc_fire && !alloc_has_exception;
    end

    // Build the slot written at the tail; a faulted fetch is complete at once
    always_comb begin
        alloc_entry                   = '0;
        alloc_entry.valid             = 1'b1;
        alloc_entry.done              = alloc_has_exception;
        alloc_entry.pc                = alloc_pc;
        alloc_entry.exc.has_exception = alloc_has_exception;
        if (alloc_has_exception) begin
            alloc_entry.exc.ecode    = alloc_ecode;
            alloc_entry.exc.esubcode = alloc_esubcode;
            alloc_entry.exc.maddr    = alloc_maddr;
        end
    end

    // Find the oldest slot still waiting for memory, starting at fill and
    // stepping over faulted or already-retired slots
    always_comb begin
        fill_found = 1'b0;
        fill_hit   = fill;
        probe      = fill;
        for (int i = 0; i < DEPTH; i++) begin
            probe = fill + PTR_W'(i);
            if (!fill_found && entries[probe].valid && !entries[probe].done) begin
                fill_found = 1'b1;
                fill_hit   = probe;
            end
        end
    end

    // Head presentation; empty slots are kept zeroed so outputs read 0
    always_comb begin
        head_entry          = entries[head];
        out_valid           = head_entry.valid && head_entry.done && !flush;
        deq                 = out_valid && out_ready;
        inst_out            = head_entry.valid ? head_entry.inst : 32'h0;
        pc_out              = head_entry.valid ? head_entry.pc : 32'h0;
        has_exception_out   = head_entry.valid && head_entry.exc.has_exception;
        ecode_out           = head_entry.valid ? head_entry.exc.ecode : '0;
        esubcode_out        = head_entry.valid ? head_entry.exc.esubcode : '0;
        exception_maddr_out = head_entry.valid ? head_entry.exc.maddr : 32'h0;
    end

    // Slot storage and pointers; flush wins over every other update
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            fill  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                entries[tail] <= alloc_entry;
                tail          <= tail + PTR_W'(1);
            end
            if (fill_en && fill_found) begin
                entries[fill_hit].inst <= rdata;
                entries[fill_hit].done <= 1'b1;
                fill                   <= fill_hit + PTR_W'(1);
            end
            if (deq) begin
                entries[head] <= '0;
                head          <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(alloc_fire) - CNT_W'(deq);
        end
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parametrised successor to the single-entry instruction-wait stage.
- Sits between IF (sram-like address handshake) and ID.
- Tracks up to MAX_OUTSTANDING in-order fetch requests and buffers up to DEPTH fetched instructions with their PC and exception info.
- On a flush, it counts the in-flight responses that must be discarded, so stale data_ok beats never reach ID.

Parameters:
- DEPTH, 4: queue entries (power of 2, ≥2).
- MAX_OUTSTANDING, 3: max memory requests in flight, including ones to be discarded; must be ≤ DEPTH.
- CNT_W, $clog2(DEPTH+1): occupancy counter width.
- DIS_W, $clog2(MAX_OUTSTANDING+1): discard counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  IF entry valid: either an address handshake completed (addr_ok && req) or a pre-faulted fetch.
- alloc_ready  out  1  queue can accept an allocation this cycle.
- alloc_pc  in  32  fetch PC.
- alloc_has_exception  in  1  fetch faulted in IF; no memory response expected.
- alloc_ecode  in  6  exception code.
- alloc_esubcode  in  9  exception subcode.
- alloc_maddr  in  32  exception bad address.
- data_ok  in  1  sram-like response beat, in request order.
- rdata  in  32  response data.
- flush  in  1  any redirect: exception, ertn, branch, tlb, csr, or cacop refetch, OR-ed upstream.
- out_valid  out  1  head entry complete and presentable to ID.
- out_ready  in  1  ID accepts.
- inst_out  out  32  head instruction; 0 for faulted entries.
- pc_out  out  32  head PC.
- has_exception_out  out  1  head exception flag.
- ecode_out  out  6  head exception code.
- esubcode_out  out  9  head exception subcode.
- exception_maddr_out  out  32  head exception bad address.
- inflight  out  DIS_W  live requests awaiting data (debug/perf).
- discard  out  DIS_W  responses pending discard.

Behaviour:
- Storage: DEPTH entries, each {valid, done, pc, inst, exc fields}.
  - Pointers head, tail, fill; wrap modulo DEPTH.
  - Counters count (CNT_W) and discard (DIS_W).
- Reset: all entries invalid; head = tail = fill = 0; count = discard = inflight = 0. out_valid = 0; all data outputs 0.
- alloc_ready = !rst && count < DEPTH && (inflight + discard) < MAX_OUTSTANDING. This holds regardless of flush.
- Allocation: on alloc_valid && alloc_ready, write entry[tail] and advance tail.
  - done = alloc_has_exception; inst = 0.
  - A non-faulted allocation increments inflight.
- Fill on data_ok:
  - If discard ≠ 0: decrement discard; no entry is written.
  - Else: write rdata into entry[fill], set done, decrement inflight, advance fill past the written entry.
  - fill always skips entries allocated with done = 1. Faulted entries never consume a data_ok.
- Output:
  - out_valid = entry[head].valid && entry[head].done && !flush.
  - Data outputs are driven directly from entry[head] (registered storage); they are 0 when the head is invalid.
  - Latency: data_ok in cycle t gives out_valid in t+1 at the earliest.
  - Dequeue on out_valid && out_ready: clear the entry and advance head.
- Simultaneous alloc + dequeue: count unchanged. Full queue + dequeue: alloc_ready stays 0 in that cycle (no same-cycle pass-through).
- Flush, applied at the next edge and taking priority over dequeue:
  - All entries invalid; head = tail = fill = 0; count = 0; inflight = 0.
  - discard_next = discard + inflight + A − D, where:
    - A = 1 if a non-faulted allocation fires this cycle (memory already accepted it);
    - D = 1 if data_ok arrives this cycle with discard == 0.
  - When discard ≠ 0 and data_ok arrives in the flush cycle: discard_next = discard − 1 + inflight + A.
- Back-to-back flushes accumulate correctly. discard never exceeds MAX_OUTSTANDING (guaranteed by alloc_ready).
- A data_ok with inflight == 0 and discard == 0 is a protocol error. The design asserts in simulation; RTL ignores the beat.
- Reset mid-operation clears everything, including discard. The memory side is reset in the same cycle.

Decomposition:
- Shared package (cpu_pkg): ECODE_W = 6, ESUBCODE_W = 9, and a fetch_exc_t struct {has_exception, ecode, esubcode, maddr} reused by IF/ID.
- One sub-module, fetch_discard_ctr: holds the inflight/discard counters and the flush arithmetic. Inputs: alloc_mem, data_ok, flush. Outputs: inflight, discard, fill_en.
- Queue storage and pointer logic stay in the top module.

Test Plan:
- Three allocs at PCs 0x1c000000/04/08, data_ok on consecutive cycles with rdata 0xA, 0xB, 0xC, out_ready = 1 → out_valid one cycle after each data_ok; inst_out 0xA, 0xB, 0xC with matching PCs; inflight returns to 0.
- Flush while inflight = 2, then two data_ok (0xDEAD, 0xBEEF), then alloc PC 0x1c000100 and data_ok 0x1234 → discard goes 2→1→0; out_valid never high for the stale beats; only 0x1234 is presented, with pc_out = 0x1c000100.
- Alloc and data_ok in the same cycle as flush, with inflight = 1 → discard_next = 1 + 1 − 1 = 1; the next data_ok is dropped.
- Faulted alloc (ecode 0x08, maddr 0x1c000003) queued behind a pending fetch; data_ok 0x55 arrives → 0x55 fills the first entry, not the faulted one. Order out: 0x55, then the fault entry with inst_out = 0 and has_exception_out = 1.
- out_ready held 0 with DEPTH = 4, MAX_OUTSTANDING = 3 → alloc_ready drops after 3 allocations (outstanding limit), then after 4 allocations once the data returns (full); release out_ready → entries dequeue 1 per cycle in order.
- rst asserted with discard = 2 and the queue half full → the next cycle has out_valid = 0, discard = 0, alloc_ready = 1.
